// File: rtl/mdio_responder.sv
// Clause 22 MDIO PHY-side responder: oversamples MDC on clk, decodes frames for
// PHY_ADDR and serves a 32 x 16-bit register file with read-only ID/status words.
module mdio_responder #(
    parameter logic [4:0]  PHY_ADDR     = 5'd1,
    parameter logic [15:0] PHY_ID1      = 16'h0141,
    parameter logic [15:0] PHY_ID2      = 16'h0CC2,
    parameter logic [15:0] STATUS_BASE  = 16'h7949,
    parameter int          PREAMBLE_MIN = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oen,
    input  logic        link_up,
    output logic        wr_strobe,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        frame_err
);
    typedef enum logic [2:0] {
        S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA_RD, S_DATA_WR
    } state_t;

    localparam logic [5:0] PRE_MIN = 6'(PREAMBLE_MIN);
    localparam logic [5:0] PRE_SAT = 6'd32;

    state_t      state;
    logic [1:0]  mdc_sync;
    logic [1:0]  mdio_sync;
    logic        mdc_prev;
    logic        mdc_rise;
    logic        bit_in;
    logic [5:0]  pre_cnt;
    logic [4:0]  bit_cnt;
    logic        op_hi;
    logic        is_read;
    logic [4:0]  phyad;
    logic [4:0]  regad;
    logic [15:0] shreg;
    logic [15:0] wr_word;
    logic [15:0] rd_word;
    logic [15:0] regs [32];

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    // mdc stages reset high so a master holding mdc high at reset release is not seen as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdc_sync  <= 2'b11;
            mdc_prev  <= 1'b1;
            mdio_sync <= 2'b11;
        end else begin
            mdc_sync  <= {mdc_sync[0], mdc};
            mdc_prev  <= mdc_sync[1];
            mdio_sync <= {mdio_sync[0], mdio_in};
        end
    end

    assign mdc_rise = mdc_sync[1] & ~mdc_prev;
    assign bit_in   = mdio_sync[1];
    assign wr_word  = {shreg[14:0], bit_in};

    // NOTE: every always_comb output gets a default before any branch, so no path
    // can leave it unassigned and infer a latch.
    always_comb begin
        rd_word = regs[regad];
        case (regad)
            5'd1:    begin
                rd_word    = STATUS_BASE;
                rd_word[2] = link_up;
            end
            5'd2:    rd_word = PHY_ID1;
            5'd3:    rd_word = PHY_ID2;
            default: ;
        endcase
    end

    // NOTE: the register file has architectural reset values, so it is built from
    // flops cleared in the reset branch rather than an inferred RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pre_cnt   <= '0;
            bit_cnt   <= '0;
            op_hi     <= 1'b0;
            is_read   <= 1'b0;
            phyad     <= '0;
            regad     <= '0;
            shreg     <= '0;
            mdio_oen  <= 1'b1;
            mdio_out  <= 1'b1;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            if (mdc_rise) begin
                case (state)
                    S_IDLE: begin
                        if (bit_in) begin
                            if (pre_cnt != PRE_SAT) pre_cnt <= pre_cnt + 6'd1;
                        end else if (pre_cnt >= PRE_MIN) begin
                            pre_cnt <= '0;
                            state   <= S_ST;
                        end else begin
                            pre_cnt <= '0;
                        end
                    end
                    S_ST: begin
                        bit_cnt <= '0;
                        if (bit_in) begin
                            state <= S_OP;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end
                    S_OP: begin
                        op_hi <= bit_in;
                        if (bit_cnt == 5'd1) begin
                            bit_cnt <= '0;
                            unique case ({op_hi, bit_in})
                                2'b10:   begin is_read <= 1'b1; state <= S_PHYAD; end
                                2'b01:   begin is_read <= 1'b0; state <= S_PHYAD; end
                                default: begin frame_err <= 1'b1; state <= S_IDLE; end
                            endcase
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    S_PHYAD: begin
                        phyad <= {phyad[3:0], bit_in};
                        if (bit_cnt == 5'd4) begin
                            bit_cnt <= '0;
                            state   <= S_REGAD;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    S_REGAD: begin
                        regad <= {regad[3:0], bit_in};
                        if (bit_cnt == 5'd4) begin
                            bit_cnt <= '0;
                            state   <= (phyad == PHY_ADDR) ? S_TA : S_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    S_TA: begin
                        // A read grabs its data on TA bit 1 and drives the TA bit 2 zero.
                        if (is_read) begin
                            shreg    <= rd_word;
                            mdio_oen <= 1'b0;
                            mdio_out <= 1'b0;
                            bit_cnt  <= '0;
                            state    <= S_DATA_RD;
                        end else if (bit_cnt == 5'd1) begin
                            bit_cnt <= '0;
                            state   <= S_DATA_WR;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    S_DATA_RD: begin
                        if (bit_cnt == 5'd16) begin
                            mdio_oen <= 1'b1;
                            mdio_out <= 1'b1;
                            bit_cnt  <= '0;
                            state    <= S_IDLE;
                        end else begin
                            mdio_out <= shreg[15];
                            shreg    <= {shreg[14:0], 1'b0};
                            bit_cnt  <= bit_cnt + 5'd1;
                        end
                    end
                    S_DATA_WR: begin
                        shreg <= wr_word;
                        if (bit_cnt == 5'd15) begin
                            wr_strobe <= 1'b1;
                            wr_addr   <= regad;
                            wr_data   <= wr_word;
                            // Registers 1..3 are synthesised on read; bit 0.15 self-clears.
                            if (regad == 5'd0)
                                regs[0] <= {1'b0, wr_word[14:0]};
                            else if (regad > 5'd3)
                                regs[regad] <= wr_word;
                            bit_cnt <= '0;
                            state   <= S_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                endcase
            end
        end
    end
endmodule
